// File: rtl/uart_pkg.sv
// Shared definitions for the extended UART receiver: FSM state encoding,
// supported oversampling ratios and the internal edge-counter width.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_e;

  // Edge counter must reach 31 for the largest ratio
  localparam int CNT_W = 6;

  localparam logic [CNT_W-1:0] PRESC_8  = 6'd8;
  localparam logic [CNT_W-1:0] PRESC_16 = 6'd16;
  localparam logic [CNT_W-1:0] PRESC_32 = 6'd32;

endpackage

// File: rtl/uart_rx_ext_sampler.sv
// Per-bit edge counter plus 3-sample majority voter around the bit centre.
// o_last marks the final edge of a bit; o_bit holds the voted value of that bit.
module uart_rx_ext_sampler
  import uart_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_active,
  input  logic             i_rx,
  input  logic [CNT_W-1:0] i_presc,
  output logic             o_last,
  output logic             o_bit
);

  localparam logic [CNT_W-1:0] ONE = 1;

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_half;
  logic             r_s0;
  logic             r_s1;
  logic             r_bit;

  assign w_half = i_presc >> 1;
  assign o_last = (r_cnt == i_presc - ONE);
  assign o_bit  = r_bit;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
      r_s0  <= 1'b1;
      r_s1  <= 1'b1;
      r_bit <= 1'b1;
    end else if (!i_active) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= o_last ? '0 : r_cnt + ONE;
      if (r_cnt == w_half - ONE) r_s0 <= i_rx;
      if (r_cnt == w_half)       r_s1 <= i_rx;
      if (r_cnt == w_half + ONE)
        r_bit <= (r_s0 & r_s1) | (r_s0 & i_rx) | (r_s1 & i_rx);
    end
  end

endmodule

// File: rtl/uart_rx_ext.sv
// Oversampling UART receiver with runtime prescale/parity/stop configuration.
// Define UART_RX_EXT_SYNC_EN to pass rx_in through a 2-flop synchroniser.
module uart_rx_ext
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_in,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  par_en,
  input  logic                  par_typ,
  input  logic                  stop2,
  output logic [DATA_WIDTH-1:0] p_data,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err
);

  localparam logic [3:0] BIT_LAST = 4'(DATA_WIDTH - 1);

  rx_state_e             r_state;
  logic [CNT_W-1:0]      r_presc;
  logic                  r_par_en;
  logic                  r_par_typ;
  logic                  r_stop2;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [3:0]            r_bit_idx;
  logic                  r_stop_idx;
  logic                  r_par_bad;
  logic                  r_stp_bad;
  logic                  w_rx;
  logic                  w_active;
  logic                  w_last;
  logic                  w_bit;
  logic [CNT_W-1:0]      w_presc_new;

`ifdef UART_RX_EXT_SYNC_EN
  logic r_sync1;
  logic r_sync2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_rx = r_sync2;
`else
  assign w_rx = rx_in;
`endif

  // Unsupported ratios fall back to 8 so the counter always has a sane period
  // NOTE: the default assignment up front keeps this block free of inferred latches.
  always_comb begin
    w_presc_new = PRESC_8;
    case (32'(prescale))
      32'(PRESC_16): w_presc_new = PRESC_16;
      32'(PRESC_32): w_presc_new = PRESC_32;
      default:       w_presc_new = PRESC_8;
    endcase
  end

  assign w_active = (r_state != IDLE);

  uart_rx_ext_sampler u_sampler (
    .clk      (clk),
    .rst      (rst),
    .i_active (w_active),
    .i_rx     (w_rx),
    .i_presc  (r_presc),
    .o_last   (w_last),
    .o_bit    (w_bit)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_presc    <= PRESC_8;
      r_par_en   <= 1'b0;
      r_par_typ  <= 1'b0;
      r_stop2    <= 1'b0;
      r_shift    <= '0;
      r_bit_idx  <= '0;
      r_stop_idx <= 1'b0;
      r_par_bad  <= 1'b0;
      r_stp_bad  <= 1'b0;
      p_data     <= '0;
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
      case (r_state)
        IDLE: begin
          if (!w_rx) begin
            r_state    <= START;
            r_presc    <= w_presc_new;
            r_par_en   <= par_en;
            r_par_typ  <= par_typ;
            r_stop2    <= stop2;
            r_bit_idx  <= '0;
            r_stop_idx <= 1'b0;
            r_par_bad  <= 1'b0;
            r_stp_bad  <= 1'b0;
          end
        end
        START: begin
          if (w_last) r_state <= w_bit ? IDLE : DATA;
        end
        DATA: begin
          if (w_last) begin
            r_shift <= {w_bit, r_shift[DATA_WIDTH-1:1]};
            if (r_bit_idx == BIT_LAST) r_state <= r_par_en ? PARITY : STOP;
            else                       r_bit_idx <= r_bit_idx + 4'd1;
          end
        end
        PARITY: begin
          if (w_last) begin
            r_par_bad <= (w_bit != (^r_shift ^ r_par_typ));
            r_state   <= STOP;
          end
        end
        STOP: begin
          if (w_last) begin
            if (r_stop2 && !r_stop_idx) begin
              r_stop_idx <= 1'b1;
              r_stp_bad  <= ~w_bit;
            end else begin
              // Frame complete: either a good word or an error pulse, never both
              r_state <= IDLE;
              if (r_par_bad || r_stp_bad || !w_bit) begin
                par_err <= r_par_bad;
                stp_err <= r_stp_bad | ~w_bit;
              end else begin
                data_valid <= 1'b1;
                p_data     <= r_shift;
              end
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_ext.sv
// Self-checking bench for uart_rx_ext: an 8-bit and a 7-bit instance driven by a
// bit-level transmitter, with expected events derived from the transmitted bit list.
module tb_uart_rx_ext;

  typedef struct packed {
    logic       dv;
    logic       pe;
    logic       se;
    logic [8:0] data;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx8;
  logic       rx7;
  logic [5:0] prescale;
  logic       par_en;
  logic       par_typ;
  logic       stop2;
  logic [7:0] p_data8;
  logic       dv8, pe8, se8;
  logic [6:0] p_data7;
  logic       dv7, pe7, se7;

  int   errors = 0;
  int   checks = 0;
  int   dbl    = 0;
  logic pdv8 = 0, ppe8 = 0, pse8 = 0, pdv7 = 0, ppe7 = 0, pse7 = 0;
  logic [8:0] good8 = '0;
  logic [8:0] good7 = '0;
  bit   tx_bits[$];
  ev_t  obs8[$], obs7[$], exp8[$], exp7[$];

  always #5 clk = ~clk;

  uart_rx_ext #(.DATA_WIDTH(8), .PRESCALE_W(6)) dut8 (
    .clk(clk), .rst(rst), .rx_in(rx8), .prescale(prescale), .par_en(par_en),
    .par_typ(par_typ), .stop2(stop2), .p_data(p_data8), .data_valid(dv8),
    .par_err(pe8), .stp_err(se8)
  );

  uart_rx_ext #(.DATA_WIDTH(7), .PRESCALE_W(6)) dut7 (
    .clk(clk), .rst(rst), .rx_in(rx7), .prescale(prescale), .par_en(par_en),
    .par_typ(par_typ), .stop2(stop2), .p_data(p_data7), .data_valid(dv7),
    .par_err(pe7), .stp_err(se7)
  );

  // Event monitor and consecutive-pulse detector
  always @(negedge clk) begin
    if (dv8 || pe8 || se8) obs8.push_back('{dv8, pe8, se8, {1'b0, p_data8}});
    if (dv7 || pe7 || se7) obs7.push_back('{dv7, pe7, se7, {2'b00, p_data7}});
    if ((dv8 && pdv8) || (pe8 && ppe8) || (se8 && pse8) ||
        (dv7 && pdv7) || (pe7 && ppe7) || (se7 && pse7)) dbl++;
    pdv8 = dv8; ppe8 = pe8; pse8 = se8;
    pdv7 = dv7; ppe7 = pe7; pse7 = se7;
  end

  task automatic idle(input int n);
    rx8 = 1'b1;
    rx7 = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Builds the serial frame, predicts the receiver outcome from the bit list,
  // then drives it; config inputs are scrambled mid start bit.
  task automatic send_frame(input int sel, input logic [8:0] data, input int p_req,
                            input logic pen, input logic ptyp, input logic s2,
                            input bit bad_par, input int bad_stop);
    int         width, p_eff, ones, idx;
    logic [8:0] d, rd;
    logic       perr, serr;
    ev_t        ev;
    width = (sel == 7) ? 7 : 8;
    p_eff = (p_req == 16 || p_req == 32) ? p_req : 8;
    d = '0;
    for (int i = 0; i < width; i++) d[i] = data[i];
    tx_bits.delete();
    tx_bits.push_back(1'b0);
    for (int i = 0; i < width; i++) tx_bits.push_back(d[i]);
    if (pen) tx_bits.push_back((^d) ^ ptyp ^ bad_par);
    tx_bits.push_back(bad_stop != 1);
    if (s2) tx_bits.push_back(bad_stop != 2);

    rd = '0;
    for (int i = 0; i < width; i++) rd[i] = tx_bits[1 + i];
    idx  = 1 + width;
    perr = 1'b0;
    if (pen) begin
      ones = $countones(rd) + int'(tx_bits[idx]);
      perr = ((ones % 2) != int'(ptyp));
      idx++;
    end
    serr = !tx_bits[idx] || (s2 && !tx_bits[idx + 1]);
    if (perr || serr) begin
      ev = '{1'b0, perr, serr, (sel == 7) ? good7 : good8};
    end else begin
      ev = '{1'b1, 1'b0, 1'b0, rd};
      if (sel == 7) good7 = rd; else good8 = rd;
    end
    if (sel == 7) exp7.push_back(ev); else exp8.push_back(ev);

    prescale = 6'(p_req);
    par_en   = pen;
    par_typ  = ptyp;
    stop2    = s2;
    for (int b = 0; b < tx_bits.size(); b++) begin
      for (int c = 0; c < p_eff; c++) begin
        @(negedge clk);
        if (sel == 7) rx7 = tx_bits[b]; else rx8 = tx_bits[b];
        if (b == 0 && c == p_eff / 2) begin
          prescale = 6'($urandom);
          par_en   = 1'($urandom);
          par_typ  = 1'($urandom);
          stop2    = 1'($urandom);
        end
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (p_data8 !== 8'h00) begin errors++; $display("FAIL reset_p_data8: got %h want 00", p_data8); end
    checks++; if ({dv8, pe8, se8} !== 3'b000) begin errors++; $display("FAIL reset_flags8: got %b want 000", {dv8, pe8, se8}); end
    checks++; if (p_data7 !== 7'h00) begin errors++; $display("FAIL reset_p_data7: got %h want 00", p_data7); end
    checks++; if ({dv7, pe7, se7} !== 3'b000) begin errors++; $display("FAIL reset_flags7: got %b want 000", {dv7, pe7, se7}); end
    rst = 1'b1;
    idle(5);
  endtask

  task automatic test_8n1();
    obs8.delete(); exp8.delete();
    send_frame(8, 9'h0A5, 8, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    idle(8);
    checks++;
    if (obs8.size() != exp8.size()) begin errors++; $display("FAIL 8n1_count: got %0d want %0d", obs8.size(), exp8.size()); end
    else foreach (exp8[i]) begin
      checks++;
      if (obs8[i] !== exp8[i]) begin errors++; $display("FAIL 8n1_event[%0d]: got %b/%b/%b %h want %b/%b/%b %h", i, obs8[i].dv, obs8[i].pe, obs8[i].se, obs8[i].data, exp8[i].dv, exp8[i].pe, exp8[i].se, exp8[i].data); end
    end
    checks++; if (p_data8 !== 8'hA5) begin errors++; $display("FAIL 8n1_p_data: got %h want a5", p_data8); end
  endtask

  task automatic test_parity7();
    obs7.delete(); exp7.delete();
    send_frame(7, 9'h02A, 16, 1'b1, 1'b0, 1'b1, 1'b0, 0);
    idle(8);
    send_frame(7, 9'h055, 16, 1'b1, 1'b0, 1'b1, 1'b1, 0);
    idle(8);
    checks++;
    if (obs7.size() != exp7.size()) begin errors++; $display("FAIL parity7_count: got %0d want %0d", obs7.size(), exp7.size()); end
    else foreach (exp7[i]) begin
      checks++;
      if (obs7[i] !== exp7[i]) begin errors++; $display("FAIL parity7_event[%0d]: got %b/%b/%b %h want %b/%b/%b %h", i, obs7[i].dv, obs7[i].pe, obs7[i].se, obs7[i].data, exp7[i].dv, exp7[i].pe, exp7[i].se, exp7[i].data); end
    end
    checks++; if (p_data7 !== 7'h2A) begin errors++; $display("FAIL parity7_p_data: got %h want 2a", p_data7); end
  endtask

  task automatic test_stop_err();
    obs8.delete(); exp8.delete();
    send_frame(8, 9'h03C, 32, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    idle(8);
    checks++;
    if (obs8.size() != exp8.size()) begin errors++; $display("FAIL stop_err_count: got %0d want %0d", obs8.size(), exp8.size()); end
    else foreach (exp8[i]) begin
      checks++;
      if (obs8[i] !== exp8[i]) begin errors++; $display("FAIL stop_err_event[%0d]: got %b/%b/%b %h want %b/%b/%b %h", i, obs8[i].dv, obs8[i].pe, obs8[i].se, obs8[i].data, exp8[i].dv, exp8[i].pe, exp8[i].se, exp8[i].data); end
    end
  endtask

  task automatic test_glitch();
    obs8.delete(); exp8.delete();
    prescale = 6'd16; par_en = 1'b0; par_typ = 1'b0; stop2 = 1'b0;
    repeat (3) begin @(negedge clk); rx8 = 1'b0; end
    idle(40);
    checks++; if (obs8.size() != 0) begin errors++; $display("FAIL glitch_no_pulse: got %0d events want 0", obs8.size()); end
    send_frame(8, 9'h081, 16, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    idle(8);
    checks++;
    if (obs8.size() != exp8.size()) begin errors++; $display("FAIL glitch_count: got %0d want %0d", obs8.size(), exp8.size()); end
    else foreach (exp8[i]) begin
      checks++;
      if (obs8[i] !== exp8[i]) begin errors++; $display("FAIL glitch_event[%0d]: got %b/%b/%b %h want %b/%b/%b %h", i, obs8[i].dv, obs8[i].pe, obs8[i].se, obs8[i].data, exp8[i].dv, exp8[i].pe, exp8[i].se, exp8[i].data); end
    end
    checks++; if (p_data8 !== 8'h81) begin errors++; $display("FAIL glitch_p_data: got %h want 81", p_data8); end
  endtask

  task automatic test_back_to_back();
    obs8.delete(); exp8.delete();
    send_frame(8, 9'h012, 16, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    send_frame(8, 9'h034, 16, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    idle(8);
    checks++;
    if (obs8.size() != 2 || exp8.size() != 2) begin errors++; $display("FAIL b2b_count: got %0d want 2", obs8.size()); end
    else foreach (exp8[i]) begin
      checks++;
      if (obs8[i] !== exp8[i]) begin errors++; $display("FAIL b2b_event[%0d]: got %b/%b/%b %h want %b/%b/%b %h", i, obs8[i].dv, obs8[i].pe, obs8[i].se, obs8[i].data, exp8[i].dv, exp8[i].pe, exp8[i].se, exp8[i].data); end
    end
  endtask

  task automatic test_reset_mid_frame();
    obs8.delete(); exp8.delete(); obs7.delete(); exp7.delete();
    prescale = 6'd8; par_en = 1'b0; par_typ = 1'b0; stop2 = 1'b0;
    repeat (8) begin @(negedge clk); rx8 = 1'b0; end
    repeat (8) begin @(negedge clk); rx8 = 1'b1; end
    repeat (8) begin @(negedge clk); rx8 = 1'b0; end
    repeat (8) begin @(negedge clk); rx8 = 1'b1; end
    #3 rst = 1'b0;
    #1;
    checks++; if (p_data8 !== 8'h00) begin errors++; $display("FAIL midrst_p_data8: got %h want 00", p_data8); end
    checks++; if ({dv8, pe8, se8} !== 3'b000) begin errors++; $display("FAIL midrst_flags8: got %b want 000", {dv8, pe8, se8}); end
    checks++; if (p_data7 !== 7'h00) begin errors++; $display("FAIL midrst_p_data7: got %h want 00", p_data7); end
    good8 = '0;
    good7 = '0;
    idle(4);
    rst = 1'b1;
    idle(10);
    checks++; if (obs8.size() != 0) begin errors++; $display("FAIL midrst_no_pulse: got %0d events want 0", obs8.size()); end
    send_frame(8, 9'h0F0, 8, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    idle(8);
    checks++;
    if (obs8.size() != exp8.size()) begin errors++; $display("FAIL midrst_count: got %0d want %0d", obs8.size(), exp8.size()); end
    else foreach (exp8[i]) begin
      checks++;
      if (obs8[i] !== exp8[i]) begin errors++; $display("FAIL midrst_event[%0d]: got %b/%b/%b %h want %b/%b/%b %h", i, obs8[i].dv, obs8[i].pe, obs8[i].se, obs8[i].data, exp8[i].dv, exp8[i].pe, exp8[i].se, exp8[i].data); end
    end
    checks++; if (p_data8 !== 8'hF0) begin errors++; $display("FAIL midrst_p_data: got %h want f0", p_data8); end
  endtask

  task automatic test_random();
    int p_tab[5] = '{8, 16, 32, 12, 0};
    int   sel, p_req, bad_stop;
    logic pen, ptyp, s2;
    bit   bad_par;
    obs8.delete(); exp8.delete(); obs7.delete(); exp7.delete();
    for (int n = 0; n < 24; n++) begin
      sel      = (n % 4 == 3) ? 7 : 8;
      p_req    = p_tab[$urandom_range(0, 4)];
      pen      = 1'($urandom);
      ptyp     = 1'($urandom);
      s2       = 1'($urandom);
      bad_par  = pen && ($urandom_range(0, 4) == 0);
      bad_stop = ($urandom_range(0, 5) == 0) ? (s2 ? $urandom_range(1, 2) : 1) : 0;
      send_frame(sel, 9'($urandom), p_req, pen, ptyp, s2, bad_par, bad_stop);
      idle(4 + $urandom_range(0, 5));
    end
    checks++;
    if (obs8.size() != exp8.size()) begin errors++; $display("FAIL rand8_count: got %0d want %0d", obs8.size(), exp8.size()); end
    else foreach (exp8[i]) begin
      checks++;
      if (obs8[i] !== exp8[i]) begin errors++; $display("FAIL rand8_event[%0d]: got %b/%b/%b %h want %b/%b/%b %h", i, obs8[i].dv, obs8[i].pe, obs8[i].se, obs8[i].data, exp8[i].dv, exp8[i].pe, exp8[i].se, exp8[i].data); end
    end
    checks++;
    if (obs7.size() != exp7.size()) begin errors++; $display("FAIL rand7_count: got %0d want %0d", obs7.size(), exp7.size()); end
    else foreach (exp7[i]) begin
      checks++;
      if (obs7[i] !== exp7[i]) begin errors++; $display("FAIL rand7_event[%0d]: got %b/%b/%b %h want %b/%b/%b %h", i, obs7[i].dv, obs7[i].pe, obs7[i].se, obs7[i].data, exp7[i].dv, exp7[i].pe, exp7[i].se, exp7[i].data); end
    end
  endtask

  task automatic test_pulse_width();
    checks++;
    if (dbl != 0) begin errors++; $display("FAIL pulse_width: got %0d multi-cycle pulses want 0", dbl); end
  endtask

  initial begin
    rst      = 1'b0;
    rx8      = 1'b1;
    rx7      = 1'b1;
    prescale = 6'd8;
    par_en   = 1'b0;
    par_typ  = 1'b0;
    stop2    = 1'b0;
    test_reset();
    test_8n1();
    test_parity7();
    test_stop_err();
    test_glitch();
    test_back_to_back();
    test_reset_mid_frame();
    test_random();
    test_pulse_width();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_ext.md
UART_RX_EXT -- requirements
Module: uart_rx_ext

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, data bits per frame; legal range 5..9.
REQ-002 SHALL have parameter PRESCALE_W, default 6, width of the prescale input.
REQ-003 SHALL have port clk  input  1  sole clock.
REQ-004 SHALL have port rst  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port rx_in  input  1  serial line; idles high.
REQ-006 SHALL have port prescale  input  PRESCALE_W  oversampling ratio; legal values 8, 16, 32.
REQ-007 SHALL have port par_en  input  1  parity bit present when 1.
REQ-008 SHALL have port par_typ  input  1  0 = even parity, 1 = odd parity.
REQ-009 SHALL have port stop2  input  1  two stop bits when 1, one stop bit when 0.
REQ-010 SHALL have port p_data  output  DATA_WIDTH  received word, LSB first on the line.
REQ-011 SHALL have port data_valid  output  1  one-cycle pulse; p_data holds a good frame.
REQ-012 SHALL have port par_err  output  1  one-cycle pulse; parity mismatch.
REQ-013 SHALL have port stp_err  output  1  one-cycle pulse; a stop bit sampled low.

Function
REQ-014 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP.
REQ-015 IDLE -> START on the first cycle rx_in (post-sync) = 0; edge counter cleared to 0.
REQ-016 prescale, par_en, par_typ and stop2 SHALL be latched on entry to START and held for the whole frame; mid-frame input changes have no effect.
REQ-017 A latched prescale other than 8, 16 or 32 SHALL be treated as 8.
REQ-018 Edge counter SHALL count 0..P-1 per bit (P = latched prescale) and wrap to 0 at each bit boundary.
REQ-019 Each bit value SHALL be the majority of three samples taken at edge counts P/2-1, P/2 and P/2+1.
REQ-020 START: when edge count = P-1, a sampled 1 is a glitch -> IDLE with no output pulse; a sampled 0 -> DATA.
REQ-021 DATA: shift exactly DATA_WIDTH bits LSB-first, then -> PARITY if par_en, else -> STOP.
REQ-022 PARITY: compare the sampled bit with the computed even/odd parity over the data bits; then -> STOP.
REQ-023 STOP: sample 1 stop bit, or 2 if stop2; any stop sample = 0 flags a stop error.
REQ-024 In the cycle after the last stop bit's edge count = P-1, the block SHALL return to IDLE, and exactly one of the following SHALL occur: data_valid = 1 with p_data updated; or par_err and/or stp_err = 1 with p_data unchanged.
REQ-025 A start bit arriving immediately after the final stop bit SHALL be detected by the one-cycle IDLE pass; no frame is lost.
REQ-026 data_valid, par_err and stp_err SHALL never be high for more than one consecutive cycle.

Reset
REQ-027 rst low SHALL asynchronously force state IDLE, counters 0, p_data 0, data_valid 0, par_err 0, stp_err 0, synchroniser flops 1.
REQ-028 Reset asserted mid-frame SHALL abort the frame with no output pulse; reception resumes at the next falling edge after rst deasserts.

Configuration
REQ-029 Macro UART_RX_EXT_SYNC_EN defined: rx_in SHALL pass through a 2-flop synchroniser, adding 2 cycles of detection latency.
REQ-030 Macro UART_RX_EXT_SYNC_EN undefined: rx_in SHALL be used directly; the caller guarantees it is synchronous to clk.

Structure
REQ-031 Shared package uart_pkg SHALL hold the FSM state enum and the constants PRESC_8, PRESC_16 and PRESC_32.
REQ-032 Sub-module uart_rx_ext_sampler SHALL contain the edge counter and the 3-sample majority voter; the FSM, shift register and checks SHALL stay in the top module.

Verification
REQ-033 8N1, prescale 8, byte 0xA5 -> data_valid pulse, p_data = 0xA5, par_err = stp_err = 0.
REQ-034 DATA_WIDTH = 7, prescale 16, even parity, 2 stop bits, 0x55 with the parity bit forced wrong -> par_err pulse, no data_valid, p_data unchanged.
REQ-035 Prescale 32, stop bit driven low, byte 0x3C -> stp_err pulse, no data_valid.
REQ-036 rx_in low for 3 cycles at prescale 16 -> glitch, FSM returns to IDLE, no pulse; a following valid 0x81 -> data_valid with p_data = 0x81.
REQ-037 Two back-to-back frames 0x12 and 0x34 with no idle gap -> two data_valid pulses, in order.
REQ-038 rst asserted mid-DATA -> outputs 0 immediately; the next frame 0xF0 is received correctly.
